draw_sequencer: RTL
===================

Name: draw_sequencer

Overview:
- Parametrised front-end that runs up to N_ENG drawing engines (fillscreen, circle, reuleaux, ...) one after another, in index order.
- Drives each engine through the lab start/done handshake.
- Muxes the active engine's pixel stream onto a single vga_x/vga_y/vga_colour/vga_plot bus that feeds vga_adapter.
- Replaces ad-hoc per-task start logic in the top level. Adds an enable mask, an abort path and a completion handshake.

Parameters:
- N_ENG, 4: number of engine slots, 1..8.
- X_W, 8: pixel x width.
- Y_W, 7: pixel y width.
- C_W, 3: colour width.
- TIMEOUT_CYCLES, 32768: per-engine cycle budget; used only with SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (CLOCK_50).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run-sequence request; level, held high until done.
- en_mask  in  N_ENG  engine i runs iff en_mask[i]=1; sampled on start acceptance.
- eng_done  in  N_ENG  done from each engine.
- eng_x  in  N_ENG*X_W  packed x; slot i at [i*X_W +: X_W].
- eng_y  in  N_ENG*Y_W  packed y.
- eng_colour  in  N_ENG*C_W  packed colour.
- eng_plot  in  N_ENG  plot strobe per engine.
- eng_start  out  N_ENG  one-hot start to engines.
- vga_x  out  X_W  muxed x.
- vga_y  out  Y_W  muxed y.
- vga_colour  out  C_W  muxed colour.
- vga_plot  out  1  muxed plot.
- busy  out  1  high in RUN/RELEASE/ABORT.
- cur_idx  out  $clog2(N_ENG) (min 1)  index of selected engine.
- done  out  1  sequence complete.
- timed_out  out  1  sticky; any engine hit its budget (0 when macro is absent).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; eng_start=0; done=0; busy=0; cur_idx=0; timed_out=0; vga_plot=0. All state flops are reset.
- IDLE:
  - When start=1, latch mask_q=en_mask and clear timed_out.
  - If mask_q≠0: cur_idx = lowest set bit, go to RUN.
  - If mask_q=0: go to DONE.
  - Acceptance takes 1 cycle. eng_start[cur_idx] rises on the cycle after start is sampled.
- RUN:
  - eng_start[cur_idx]=1; all other bits 0.
  - vga_x/y/colour = slot cur_idx, combinational.
  - vga_plot = eng_plot[cur_idx]; plots from non-selected engines are ignored.
  - When eng_done[cur_idx]=1, go to RELEASE.
- RELEASE:
  - eng_start=0; vga_plot=0.
  - Wait for eng_done[cur_idx]=0, per the engine protocol: done falls after start drops.
  - Then, if a higher enabled index exists, set cur_idx to it and go to RUN. Otherwise go to DONE.
  - At least 1 dead cycle separates consecutive engines' start pulses.
- DONE:
  - done=1; busy=0; vga_plot=0.
  - Hold until start=0, then go to IDLE; done falls 1 cycle after start falls.
- ABORT: start=0 while in RUN.
  - Drop eng_start next cycle and wait for eng_done[cur_idx]=0.
  - Then go to IDLE with done never asserted.
  - start=0 while in RELEASE also ends in IDLE once done is low.
- Outside RUN: vga_x/y/colour still follow slot cur_idx; vga_plot=0.
- en_mask changes after acceptance are ignored until the next IDLE.
- eng_done of a non-selected engine is ignored in every state.
- Reset mid-operation: all outputs return to reset values immediately; engines see eng_start=0.
- Top level: fillscreen occupies slot 0, so its clear always precedes the other drawing engines.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- With the macro defined:
  - A per-engine counter clears on entry to RUN and increments each RUN cycle.
  - When it reaches TIMEOUT_CYCLES-1 without eng_done, set timed_out=1 (sticky until the next acceptance).
  - Then go to RELEASE and continue the sequence, so a hung engine cannot stall the display.
  - In RELEASE after a timeout, wait at most TIMEOUT_CYCLES for done low, then advance.
- Without the macro: no counter; timed_out is tied to 0; RUN waits indefinitely.

Test Plan:
1. Mask-0011 sequence: N_ENG=4, en_mask=4'b0011, start=1.
   - eng_start=0001 from cycle 1.
   - Engine 0 done → eng_start drops. After done low, eng_start=0010.
   - Engine 1 done/low → done=1. Drop start → done=0 next cycle, busy=0.
2. Mux check:
   - Engine 1 drives x=80, y=60, colour=3'b010, plot=1 in RUN, while engine 0 drives plot=1, x=5.
   - vga_x=80, vga_y=60, vga_colour=010, vga_plot=1; engine 0's x=5 never appears with vga_plot=1.
3. Sparse/empty masks:
   - en_mask=4'b1010 → only slots 1 and 3 ever see eng_start.
   - en_mask=0 → done=1 two cycles after start with no eng_start pulse.
4. Abort: deassert start 10 cycles into engine 0's RUN.
   - eng_start=0 next cycle. After eng_done stays low, state returns to IDLE; done never 1.
   - A new start then restarts from slot 0.
5. Reset mid-run: rst_n low mid-engine-1 → eng_start=0, vga_plot=0, busy=0, cur_idx=0 asynchronously.
6. Timeout (SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16): engine 0 never asserts done.
   - After 16 cycles, timed_out=1 and slot 1 starts.
   - Without the macro, eng_start[0] remains 1 for 1000 cycles.

Source files
------------

// File: rtl/draw_sequencer.sv
// Runs up to N_ENG drawing engines in index order through a start/done handshake and muxes the
// active engine's pixel stream onto the VGA bus. Optional per-engine watchdog: SEQ_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for start; latches en_mask on acceptance
// RUN     | eng_start[cur_idx] high, engine pixels forwarded
// RELEASE | start dropped, waiting for the engine's done to fall
// DONE    | sequence complete, done held until start falls
// ABORT   | start fell mid-run, waiting for the engine's done to fall
module draw_sequencer #(
    parameter int N_ENG          = 4,
    parameter int X_W            = 8,
    parameter int Y_W            = 7,
    parameter int C_W            = 3,
    parameter int TIMEOUT_CYCLES = 32768,
    localparam int IW            = (N_ENG > 1) ? $clog2(N_ENG) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N_ENG-1:0]     en_mask,
    input  logic [N_ENG-1:0]     eng_done,
    input  logic [N_ENG*X_W-1:0] eng_x,
    input  logic [N_ENG*Y_W-1:0] eng_y,
    input  logic [N_ENG*C_W-1:0] eng_colour,
    input  logic [N_ENG-1:0]     eng_plot,
    output logic [N_ENG-1:0]     eng_start,
    output logic [X_W-1:0]       vga_x,
    output logic [Y_W-1:0]       vga_y,
    output logic [C_W-1:0]       vga_colour,
    output logic                 vga_plot,
    output logic                 busy,
    output logic [IW-1:0]        cur_idx,
    output logic                 done,
    output logic                 timed_out
);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_RELEASE, S_DONE, S_ABORT} state_t;

    state_t           state;
    logic [N_ENG-1:0] mask_q;
    logic [IW-1:0]    first_idx;
    logic [IW-1:0]    nxt_idx;
    logic             nxt_found;
    logic             rel_go;

    function automatic logic [N_ENG-1:0] onehot(input logic [IW-1:0] idx);
        return N_ENG'(1) << idx;
    endfunction

    // Descending scans so the lowest qualifying index wins.
    always_comb begin
        first_idx = '0;
        nxt_idx   = '0;
        nxt_found = 1'b0;
        for (int i = N_ENG - 1; i >= 0; i--) begin
            if (en_mask[i]) first_idx = IW'(i);
            if (mask_q[i] && (i > int'(cur_idx))) begin
                nxt_idx   = IW'(i);
                nxt_found = 1'b1;
            end
        end
    end

    assign vga_x      = eng_x[int'(cur_idx)*X_W +: X_W];
    assign vga_y      = eng_y[int'(cur_idx)*Y_W +: Y_W];
    assign vga_colour = eng_colour[int'(cur_idx)*C_W +: C_W];
    assign vga_plot   = (state == S_RUN) && eng_plot[cur_idx];

`ifdef SEQ_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             rel_bound;
    logic             timed_out_q;

    // After a timeout the engine may never drop done, so the release wait is bounded too.
    assign rel_go    = !eng_done[cur_idx] || (rel_bound && (tmo_cnt == CNT_LAST));
    assign timed_out = timed_out_q;
`else
    assign rel_go    = !eng_done[cur_idx];
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mask_q    <= '0;
            cur_idx   <= '0;
            eng_start <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            tmo_cnt     <= '0;
            rel_bound   <= 1'b0;
            timed_out_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask_q <= en_mask;
`ifdef SEQ_TIMEOUT_EN
                        timed_out_q <= 1'b0;
                        tmo_cnt     <= '0;
`endif
                        if (en_mask != '0) begin
                            cur_idx   <= first_idx;
                            eng_start <= onehot(first_idx);
                            busy      <= 1'b1;
                            state     <= S_RUN;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (!start) begin
                        eng_start <= '0;
                        state     <= S_ABORT;
                    end else if (eng_done[cur_idx]) begin
                        eng_start <= '0;
                        state     <= S_RELEASE;
`ifdef SEQ_TIMEOUT_EN
                        tmo_cnt   <= '0;
                        rel_bound <= 1'b0;
                    end else if (tmo_cnt == CNT_LAST) begin
                        eng_start   <= '0;
                        state       <= S_RELEASE;
                        tmo_cnt     <= '0;
                        rel_bound   <= 1'b1;
                        timed_out_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                S_RELEASE: begin
`ifdef SEQ_TIMEOUT_EN
                    tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    if (rel_go) begin
                        if (!start) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else if (nxt_found) begin
                            cur_idx   <= nxt_idx;
                            eng_start <= onehot(nxt_idx);
                            state     <= S_RUN;
`ifdef SEQ_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end else begin
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                S_ABORT: begin
                    if (!eng_done[cur_idx]) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
